// File: rtl/maxpool_scheduler.sv
// Max-pooling layer sequencer: walks each PxP window of a CxHxW map through a single-outstanding
// read port and writes one pooled element per window. Optional config check: MAXPOOL_SCHED_CFG_CHECK_EN.
module maxpool_scheduler #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [9:0]        cfg_width,
  input  logic [9:0]        cfg_height,
  input  logic [9:0]        cfg_channels,
  input  logic [1:0]        cfg_pool,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

`ifdef MAXPOOL_SCHED_CFG_CHECK_EN
  localparam bit CFG_CHECK_EN = 1'b1;
`else
  localparam bit CFG_CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
  logic [9:0]        w_q, w_d, h_q, h_d, c_q, c_d, ow_q, ow_d, oh_q, oh_d;
  logic [1:0]        pool_q, pool_d, kx_q, kx_d, ky_q, ky_d;
  logic [9:0]        ox_q, ox_d, oy_q, oy_d, ch_q, ch_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic              cfg_err_q, cfg_err_d;

  logic [9:0] ow_calc, oh_calc;
  logic       cfg_invalid, last_k, last_out;

  function automatic logic [ADDR_W-1:0] in_addr(
    input logic [ADDR_W-1:0] base,
    input logic [9:0]        w, h, ch, oy, ox,
    input logic [1:0]        p, ky, kx
  );
    logic [ADDR_W-1:0] row, col;
    row = ADDR_W'(ch) * ADDR_W'(h) + ADDR_W'(oy) * ADDR_W'(p) + ADDR_W'(ky);
    col = ADDR_W'(ox) * ADDR_W'(p) + ADDR_W'(kx);
    return base + ((row * ADDR_W'(w) + col) << 2);
  endfunction

  function automatic logic [ADDR_W-1:0] out_addr(
    input logic [ADDR_W-1:0] base,
    input logic [9:0]        ch, oh, oy, ow, ox
  );
    return base + (((ADDR_W'(ch) * ADDR_W'(oh) + ADDR_W'(oy)) * ADDR_W'(ow) + ADDR_W'(ox)) << 2);
  endfunction

  // Output grid size is fixed at start so the walk never divides on the fly.
  assign ow_calc = (cfg_pool == 2'd3) ? cfg_width  / 10'd3 : cfg_width  >> 1;
  assign oh_calc = (cfg_pool == 2'd3) ? cfg_height / 10'd3 : cfg_height >> 1;

  assign cfg_invalid = (cfg_pool != 2'd2 && cfg_pool != 2'd3) ||
                       (cfg_width  < {8'd0, cfg_pool}) ||
                       (cfg_height < {8'd0, cfg_pool}) ||
                       (cfg_channels == 10'd0);

  assign last_k   = (kx_q == pool_q - 2'd1) && (ky_q == pool_q - 2'd1);
  assign last_out = (ox_q == ow_q - 10'd1) && (oy_q == oh_q - 10'd1) && (ch_q == c_q - 10'd1);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    w_d        = w_q;
    h_d        = h_q;
    c_d        = c_q;
    ow_d       = ow_q;
    oh_d       = oh_q;
    pool_d     = pool_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    ch_d       = ch_q;
    max_d      = max_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    cfg_err_d  = cfg_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          in_base_d  = cfg_in_base;
          out_base_d = cfg_out_base;
          w_d        = cfg_width;
          h_d        = cfg_height;
          c_d        = cfg_channels;
          pool_d     = cfg_pool;
          ow_d       = ow_calc;
          oh_d       = oh_calc;
          kx_d       = 2'd0;
          ky_d       = 2'd0;
          ox_d       = 10'd0;
          oy_d       = 10'd0;
          ch_d       = 10'd0;
          rd_addr_d  = cfg_in_base;
          cfg_err_d  = 1'b0;
          state_d    = S_RD_REQ;
          if (CFG_CHECK_EN && cfg_invalid) begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_RD_REQ: begin
        if (rd_ack) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_valid) begin
          // First element of a window seeds the max; ties keep the held value.
          if ((kx_q == 2'd0 && ky_q == 2'd0) || ($signed(rd_data) > $signed(max_q))) max_d = rd_data;
          if (last_k) begin
            wr_addr_d = out_addr(out_base_q, ch_q, oh_q, oy_q, ow_q, ox_q);
            state_d   = S_WR_REQ;
          end else begin
            if (kx_q == pool_q - 2'd1) begin
              kx_d = 2'd0;
              ky_d = ky_q + 2'd1;
            end else begin
              kx_d = kx_q + 2'd1;
            end
            rd_addr_d = in_addr(in_base_q, w_q, h_q, ch_q, oy_q, ox_q, pool_q, ky_d, kx_d);
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (wr_ack) begin
          if (last_out) begin
            state_d = S_DONE;
          end else begin
            kx_d = 2'd0;
            ky_d = 2'd0;
            if (ox_q == ow_q - 10'd1) begin
              ox_d = 10'd0;
              if (oy_q == oh_q - 10'd1) begin
                oy_d = 10'd0;
                ch_d = ch_q + 10'd1;
              end else begin
                oy_d = oy_q + 10'd1;
              end
            end else begin
              ox_d = ox_q + 10'd1;
            end
            rd_addr_d = in_addr(in_base_q, w_q, h_q, ch_d, oy_d, ox_d, pool_q, 2'd0, 2'd0);
            state_d   = S_RD_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      in_base_q  <= '0;
      out_base_q <= '0;
      w_q        <= '0;
      h_q        <= '0;
      c_q        <= '0;
      ow_q       <= '0;
      oh_q       <= '0;
      pool_q     <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      ch_q       <= '0;
      max_q      <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      w_q        <= w_d;
      h_q        <= h_d;
      c_q        <= c_d;
      ow_q       <= ow_d;
      oh_q       <= oh_d;
      pool_q     <= pool_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      ch_q       <= ch_d;
      max_q      <= max_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign rd_req  = (state_q == S_RD_REQ);
  assign wr_req  = (state_q == S_WR_REQ);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = max_q;
  assign cfg_err = CFG_CHECK_EN ? cfg_err_q : 1'b0;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Self-checking bench for maxpool_scheduler: a window-by-window reference model feeds expected
// read/write queues that a negedge monitor compares against every handshake.
module tb_maxpool_scheduler;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          start;
  logic [AW-1:0] cfg_in_base, cfg_out_base;
  logic [9:0]    cfg_width, cfg_height, cfg_channels;
  logic [1:0]    cfg_pool;
  logic          rd_req, rd_ack, rd_valid, wr_req, wr_ack, busy, done, cfg_err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;

  maxpool_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_channels(cfg_channels), .cfg_pool(cfg_pool),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd [$];
  wr_t         exp_wr [$];
  int          ack_dly = 0, val_dly = 0, wr_dly = 0;
  bit          chk_en = 1'b0;
  bit          col_chk = 1'b0;
  int          col_w = 1;
  logic [31:0] col_base = '0;
  int          done_cnt = 0;

  localparam logic [31:0] JUNK = 32'h7FFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  // kind 0: value = element index; kind 1: negatives with -1 at (x=2,y=2) of each 3x3 channel;
  // kind 2: small signed mix with repeats (exercises ties).
  task automatic fill_mem(input int kind, input logic [31:0] base, input int n);
    mem.delete();
    for (int i = 0; i < n; i++) begin
      int v;
      case (kind)
        0:       v = i;
        1:       v = (i % 9 == 8) ? -1 : -(10 + i);
        default: v = (i * 7) % 11 - 5;
      endcase
      mem[base + 32'(4 * i)] = 32'(v);
    end
  endtask

  task automatic build_model(input logic [31:0] ib, input logic [31:0] ob,
                             input int w, input int h, input int c, input int p);
    int ow, oh;
    ow = w / p;
    oh = h / p;
    exp_rd.delete();
    exp_wr.delete();
    for (int ch = 0; ch < c; ch++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          logic [31:0] mx;
          wr_t         e;
          mx = '0;
          for (int ky = 0; ky < p; ky++)
            for (int kx = 0; kx < p; kx++) begin
              logic [31:0] a, v;
              a = ib + 32'(4 * ((ch * h + oy * p + ky) * w + ox * p + kx));
              exp_rd.push_back(a);
              v = mem_rd(a);
              if ((kx == 0 && ky == 0) || ($signed(v) > $signed(mx))) mx = v;
            end
          e.a = ob + 32'(4 * ((ch * oh + oy) * ow + ox));
          e.d = mx;
          exp_wr.push_back(e);
        end
  endtask

  task automatic program_cfg(input logic [31:0] ib, input logic [31:0] ob,
                             input int w, input int h, input int c, input int p);
    cfg_in_base  = ib;
    cfg_out_base = ob;
    cfg_width    = 10'(w);
    cfg_height   = 10'(h);
    cfg_channels = 10'(c);
    cfg_pool     = 2'(p);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_req"},  64'(rd_req),  64'd0);
    check({tag, "_wr_req"},  64'(wr_req),  64'd0);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
  endtask

  // Launches the pass already programmed into cfg_*; optionally re-pulses start mid-pass with a
  // different configuration, which must have no effect.
  task automatic run_pass(input string tag, input bit restart);
    int n;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (restart) begin
      repeat (20) tick();
      check({tag, "_busy_mid_pass"}, 64'(busy), 64'd1);
      cfg_in_base = 32'h9000;
      cfg_width   = 10'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    repeat (5) tick();
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_reads_left"}, 64'(exp_rd.size()), 64'd0);
    check({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
  endtask

  // Read responder: ack after ack_dly cycles of request, data val_dly cycles after the ack cycle.
  initial begin
    int          ph, cnt;
    logic [31:0] lat;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = JUNK;
    ph = 0; cnt = 0; lat = '0;
    forever begin
      tick();
      if (!ARESETN) begin
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = JUNK; ph = 0; cnt = 0;
      end else begin
        if (ph == 2) begin
          rd_valid = 1'b0; rd_data = JUNK; ph = 0; cnt = 0;
        end
        if (ph == 0) begin
          if (rd_req) begin
            if (cnt >= ack_dly) begin
              rd_ack = 1'b1; lat = rd_addr; ph = 1; cnt = 0;
            end else cnt++;
          end
        end else begin
          rd_ack = 1'b0;
          if (cnt >= val_dly) begin
            rd_valid = 1'b1; rd_data = mem_rd(lat); ph = 2;
          end else cnt++;
        end
      end
    end
  end

  // Write responder: ack after wr_dly cycles of request.
  initial begin
    int cnt;
    wr_ack = 1'b0;
    cnt = 0;
    forever begin
      tick();
      if (!ARESETN) begin
        wr_ack = 1'b0; cnt = 0;
      end else if (wr_ack) begin
        wr_ack = 1'b0; cnt = 0;
      end else if (wr_req) begin
        if (cnt >= wr_dly) wr_ack = 1'b1;
        else cnt++;
      end else cnt = 0;
    end
  end

  // Compare process: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    logic [31:0] prev_rd_addr;
    bit          rd_pend, prev_done;
    prev_rd_addr = '0; rd_pend = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        rd_pend = 1'b0; prev_done = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          if (chk_en) check("done_one_cycle", 64'(prev_done), 64'd0);
        end
        prev_done = done;
        if (chk_en) begin
          check("rd_wr_mutex", 64'(rd_req & wr_req), 64'd0);
          if (rd_req && rd_pend) check("rd_addr_stable", 64'(rd_addr), 64'(prev_rd_addr));
          if (rd_req && rd_ack) begin
            if (exp_rd.size() == 0) check("rd_unexpected", 64'(rd_addr), 64'h1_0000_0000);
            else check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
            if (col_chk) begin
              int x;
              x = int'((rd_addr - col_base) >> 2) % col_w;
              check("col_x_not_4", 64'(x == 4), 64'd0);
            end
          end
          if (wr_req && wr_ack) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 64'(wr_addr), 64'h1_0000_0000);
            else begin
              wr_t e;
              e = exp_wr.pop_front();
              check("wr_addr", 64'(wr_addr), 64'(e.a));
              check("wr_data", 64'(wr_data), 64'(e.d));
            end
          end
        end
        rd_pend = rd_req && !rd_ack;
        prev_rd_addr = rd_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    start = 1'b0;
    program_cfg(32'h0, 32'h0, 4, 4, 1, 2);
    ARESETN = 1'b1;
    #2 ARESETN = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    ARESETN = 1'b1;
    tick();
    chk_en = 1'b1;

    // 4x4x1, 2x2 pool, data = index.
    fill_mem(0, 32'h1000, 16);
    build_model(32'h1000, 32'h2000, 4, 4, 1, 2);
    check("m1_reads", 64'(exp_rd.size()), 64'd16);
    check("m1_w0", {exp_wr[0].a, exp_wr[0].d}, {32'h2000, 32'd5});
    check("m1_w1", {exp_wr[1].a, exp_wr[1].d}, {32'h2004, 32'd7});
    check("m1_w2", {exp_wr[2].a, exp_wr[2].d}, {32'h2008, 32'd13});
    check("m1_w3", {exp_wr[3].a, exp_wr[3].d}, {32'h200C, 32'd15});
    program_cfg(32'h1000, 32'h2000, 4, 4, 1, 2);
    run_pass("t1", 1'b0);

    // 3x3x2, 3x3 pool, all-negative data.
    fill_mem(1, 32'h4000, 18);
    build_model(32'h4000, 32'h6000, 3, 3, 2, 3);
    check("m2_writes", 64'(exp_wr.size()), 64'd2);
    check("m2_w0", {exp_wr[0].a, exp_wr[0].d}, {32'h6000, 32'hFFFF_FFFF});
    check("m2_w1", {exp_wr[1].a, exp_wr[1].d}, {32'h6004, 32'hFFFF_FFFF});
    program_cfg(32'h4000, 32'h6000, 3, 3, 2, 3);
    run_pass("t2", 1'b0);

    // 5x4x1, 2x2 pool: trailing column skipped.
    fill_mem(2, 32'h100, 20);
    build_model(32'h100, 32'h800, 5, 4, 1, 2);
    check("m3_reads", 64'(exp_rd.size()), 64'd16);
    check("m3_writes", 64'(exp_wr.size()), 64'd4);
    check("m3_w1_addr", 64'(exp_wr[1].a), 64'h804);
    col_chk = 1'b1; col_w = 5; col_base = 32'h100;
    program_cfg(32'h100, 32'h800, 5, 4, 1, 2);
    run_pass("t3", 1'b0);
    col_chk = 1'b0;

    // Stalled handshakes and an ignored mid-pass start: same results as the first run.
    ack_dly = 3; val_dly = 5; wr_dly = 2;
    fill_mem(0, 32'h1000, 16);
    build_model(32'h1000, 32'h2000, 4, 4, 1, 2);
    program_cfg(32'h1000, 32'h2000, 4, 4, 1, 2);
    run_pass("t4", 1'b1);
    ack_dly = 0; val_dly = 0; wr_dly = 0;

    // Reset while a write is pending, then a clean rerun.
    wr_dly = 4;
    build_model(32'h1000, 32'h2000, 4, 4, 1, 2);
    program_cfg(32'h1000, 32'h2000, 4, 4, 1, 2);
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!wr_req && n < 2000) begin
      tick();
      n++;
    end
    check("t5_wr_req_reached", 64'(wr_req), 64'd1);
    chk_en = 1'b0;
    #2 ARESETN = 1'b0;
    #1 check_outputs_zero("t5_reset");
    repeat (3) tick();
    ARESETN = 1'b1;
    repeat (3) tick();
    check("t5_no_done", 64'(done_cnt), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    wr_dly = 0;
    build_model(32'h1000, 32'h2000, 4, 4, 1, 2);
    chk_en = 1'b1;
    run_pass("t5", 1'b0);

`ifdef MAXPOOL_SCHED_CFG_CHECK_EN
    // Invalid pool size: straight to DONE, no transfers, sticky error.
    exp_rd.delete();
    exp_wr.delete();
    program_cfg(32'h1000, 32'h2000, 4, 4, 1, 1);
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 5) begin
      tick();
      n++;
    end
    check("t6_done_seen", 64'(done), 64'd1);
    check("t6_done_latency_ok", 64'(n <= 1), 64'd1);
    check("t6_cfg_err", 64'(cfg_err), 64'd1);
    repeat (4) tick();
    check("t6_cfg_err_held", 64'(cfg_err), 64'd1);
    check("t6_done_pulses", 64'(done_cnt), 64'd1);
    fill_mem(0, 32'h1000, 16);
    build_model(32'h1000, 32'h2000, 4, 4, 1, 2);
    program_cfg(32'h1000, 32'h2000, 4, 4, 1, 2);
    run_pass("t6_valid", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
